// File: rtl/ccff_loader.sv
// ccff_loader: takes configuration bytes over a valid/ready stream and
// shifts them MSB-first into the fabric configuration flip-flop chain.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no session; bit counter held at zero
// S_LOAD  | waiting for the next byte from the source (in_ready high)
// S_SHIFT | serializing the current byte, 2*HALF prog_clk cycles per bit
// S_DONE  | all CHAIN_LEN bits shifted; chain outputs parked low
module ccff_loader #(
    parameter int CHAIN_LEN = 256,
    parameter int HALF      = 1,
    localparam int CW       = $clog2(CHAIN_LEN + 1)
) (
    input  logic          prog_clk,
    input  logic          pReset,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    output logic          ccff_head,
    output logic          ccff_clk,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] bit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int            TW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [TW-1:0] TMR_INIT = TW'(HALF - 1);
    localparam logic [CW-1:0] LEN      = CW'(CHAIN_LEN);
    localparam logic [CW-1:0] LAST     = CW'(CHAIN_LEN - 1);

    state_t        r_state;
    state_t        w_state_nx;
    logic [6:0]    r_sreg;
    logic [2:0]    r_bidx;
    logic          r_phase;
    logic [TW-1:0] r_tmr;
    logic [CW-1:0] r_bit_cnt;
    logic          r_ccff_clk;
    logic          r_ccff_head;

    logic          w_bit_end;
    logic          w_last;
    logic          w_byte_end;

    assign w_bit_end  = (r_state == S_SHIFT) && r_phase && (r_tmr == '0);
    assign w_last     = (r_bit_cnt == LAST);
    assign w_byte_end = (r_bidx == 3'd0);

    // State register.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode; abort overrides every other request.
    always_comb begin
        w_state_nx = r_state;
        if (abort) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_state_nx = S_LOAD;
                S_LOAD:  if (in_valid) w_state_nx = S_SHIFT;
                S_SHIFT: begin
                    if (w_bit_end) begin
                        if (w_last) begin
                            w_state_nx = S_DONE;
                        end else if (w_byte_end) begin
                            w_state_nx = S_LOAD;
                        end
                    end
                end
                S_DONE:  if (start) w_state_nx = S_LOAD;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // Serializer: phase down-counter, bit index, chain clock and data.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_sreg      <= '0;
            r_bidx      <= '0;
            r_phase     <= 1'b0;
            r_tmr       <= '0;
            r_bit_cnt   <= '0;
            r_ccff_clk  <= 1'b0;
            r_ccff_head <= 1'b0;
        end else if (abort) begin
            r_phase     <= 1'b0;
            r_tmr       <= TMR_INIT;
            r_bit_cnt   <= '0;
            r_ccff_clk  <= 1'b0;
            r_ccff_head <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt   <= '0;
                    r_ccff_clk  <= 1'b0;
                    r_ccff_head <= 1'b0;
                end
                S_LOAD: begin
                    r_ccff_clk <= 1'b0;
                    if (in_valid) begin
                        r_sreg      <= in_data[6:0];
                        r_bidx      <= 3'd7;
                        r_ccff_head <= in_data[7];
                        r_phase     <= 1'b0;
                        r_tmr       <= TMR_INIT;
                    end
                end
                S_SHIFT: begin
                    if (r_tmr != '0) begin
                        r_tmr <= r_tmr - 1'b1;
                    end else begin
                        r_tmr <= TMR_INIT;
                        if (!r_phase) begin
                            r_phase    <= 1'b1;
                            r_ccff_clk <= 1'b1;
                        end else begin
                            r_phase    <= 1'b0;
                            r_ccff_clk <= 1'b0;
                            if (r_bit_cnt != LEN) begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                            // Leaving SHIFT parks the head low; any unsent
                            // bits of the byte are simply dropped.
                            if (w_last || w_byte_end) begin
                                r_ccff_head <= 1'b0;
                            end else begin
                                r_ccff_head <= r_sreg[6];
                                r_sreg      <= {r_sreg[5:0], 1'b0};
                                r_bidx      <= r_bidx - 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_ccff_clk  <= 1'b0;
                    r_ccff_head <= 1'b0;
                    if (start) begin
                        r_bit_cnt <= '0;
                    end
                end
                default: begin
                    r_ccff_clk  <= 1'b0;
                    r_ccff_head <= 1'b0;
                end
            endcase
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        in_ready = (r_state == S_LOAD);
        busy     = (r_state == S_LOAD) || (r_state == S_SHIFT);
        done     = (r_state == S_DONE);
    end

    assign ccff_clk  = r_ccff_clk;
    assign ccff_head = r_ccff_head;
    assign bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: a per-cycle vector table for the basic 12-bit load,
// then hand-written sequences for back-pressure, abort, async reset and a
// divided chain clock on a second instance.
module tb_ccff_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A: CHAIN_LEN=12, HALF=1
    logic       a_start, a_abort, a_valid;
    logic [7:0] a_data;
    logic       a_ready, a_head, a_cclk, a_busy, a_done;
    logic [3:0] a_cnt;

    // Instance B: CHAIN_LEN=8, HALF=3
    logic       b_start, b_abort, b_valid;
    logic [7:0] b_data;
    logic       b_ready, b_head, b_cclk, b_busy, b_done;
    logic [3:0] b_cnt;

    ccff_loader #(.CHAIN_LEN(12), .HALF(1)) dut_a (
        .prog_clk(clk), .pReset(rst), .start(a_start), .abort(a_abort),
        .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .ccff_head(a_head), .ccff_clk(a_cclk), .busy(a_busy),
        .done(a_done), .bit_cnt(a_cnt)
    );

    ccff_loader #(.CHAIN_LEN(8), .HALF(3)) dut_b (
        .prog_clk(clk), .pReset(rst), .start(b_start), .abort(b_abort),
        .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .ccff_head(b_head), .ccff_clk(b_cclk), .busy(b_busy),
        .done(b_done), .bit_cnt(b_cnt)
    );

    // Chain models: capture ccff_head on each ccff_clk rise.
    int          a_rises = 0;
    logic [11:0] a_chain = '0;
    int          b_rises = 0;
    logic [7:0]  b_chain = '0;
    always @(posedge a_cclk) begin
        a_rises = a_rises + 1;
        a_chain = {a_chain[10:0], a_head};
    end
    always @(posedge b_cclk) begin
        b_rises = b_rises + 1;
        b_chain = {b_chain[6:0], b_head};
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       st;
        logic       vl;
        logic [7:0] dt;
        logic       ab;
        logic       rdy;
        logic       hd;
        logic       ck;
        logic       bs;
        logic       dn;
        logic [3:0] cn;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic st, input logic vl, input logic [7:0] dt,
                       input logic ab, input logic rdy, input logic hd,
                       input logic ck, input logic bs, input logic dn,
                       input logic [3:0] cn);
        vec_t v;
        v.st = st; v.vl = vl; v.dt = dt; v.ab = ab;
        v.rdy = rdy; v.hd = hd; v.ck = ck; v.bs = bs; v.dn = dn; v.cn = cn;
        vq.push_back(v);
    endtask

    task automatic a_pulse_start();
        @(negedge clk); a_start = 1'b1;
        @(posedge clk); #1; a_start = 1'b0;
    endtask

    task automatic a_send(input logic [7:0] d);
        int c;
        c = 0;
        @(negedge clk); a_valid = 1'b1; a_data = d;
        while (!a_ready && c < 100) begin
            @(negedge clk); c++;
        end
        @(posedge clk); #1; a_valid = 1'b0;
        chk("a_send wait", c < 100, 1);
    endtask

    task automatic a_wait_done(input string nm);
        int c;
        c = 0;
        while (!a_done && c < 200) begin
            @(posedge clk); #1; c++;
        end
        chk(nm, a_done, 1);
    endtask

    initial begin
        logic [11:0] stream;
        logic [47:0] pat;
        logic        bt;
        int          sc;
        int          c;

        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] stream;
        logic [47:0] pat;
        logic        bt;
        int          sc;
        int          c;

        a_start = 0; a_abort = 0; a_valid = 0; a_data = '0;
        b_start = 0; b_abort = 0; b_valid = 0; b_data = '0;

        // Reset state
        #2 rst = 1'b1;
        #20;
        chk("rst a_ready", a_ready, 0);
        chk("rst a_head",  a_head,  0);
        chk("rst a_clk",   a_cclk,  0);
        chk("rst a_busy",  a_busy,  0);
        chk("rst a_done",  a_done,  0);
        chk("rst a_cnt",   a_cnt,   0);
        chk("rst b_ready", b_ready, 0);
        chk("rst b_busy",  b_busy,  0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("idle a_ready", a_ready, 0);
        a_rises = 0;

        // Basic load table: 0xA5, 0x3C into a 12-bit chain, zero-wait source.
        stream = 12'hA53;
        add(1, 0, 8'h00, 0,  1, 0, 0, 1, 0, 4'd0);
        add(0, 1, 8'hA5, 0,  0, 1, 0, 1, 0, 4'd0);
        for (int i = 0; i < 12; i++) begin
            bt = stream[11-i];
            // high phase; start while busy and a byte offered in SHIFT are ignored
            add(i == 3, i == 7, 8'h3C, 0,  0, bt, 1, 1, 0, 4'(i));
            if (i == 7) begin
                add(0, 1, 8'h3C, 0,  1, 0, 0, 1, 0, 4'd8);
                add(0, 1, 8'h3C, 0,  0, stream[3], 0, 1, 0, 4'd8);
            end else if (i == 11) begin
                add(0, 0, 8'h00, 0,  0, 0, 0, 0, 1, 4'd12);
            end else begin
                bt = stream[10-i];
                add(0, 0, 8'h00, 0,  0, bt, 0, 1, 0, 4'(i + 1));
            end
        end
        add(0, 0, 8'h00, 0,  0, 0, 0, 0, 1, 4'd12);

        foreach (vq[k]) begin
            @(negedge clk);
            a_start = vq[k].st; a_valid = vq[k].vl;
            a_data  = vq[k].dt; a_abort = vq[k].ab;
            @(posedge clk); #1;
            chk($sformatf("vec%0d ready", k), a_ready, vq[k].rdy);
            chk($sformatf("vec%0d head",  k), a_head,  vq[k].hd);
            chk($sformatf("vec%0d cclk",  k), a_cclk,  vq[k].ck);
            chk($sformatf("vec%0d busy",  k), a_busy,  vq[k].bs);
            chk($sformatf("vec%0d done",  k), a_done,  vq[k].dn);
            chk($sformatf("vec%0d cnt",   k), a_cnt,   vq[k].cn);
        end
        @(negedge clk);
        a_start = 0; a_valid = 0; a_data = '0; a_abort = 0;
        chk("basic rises", a_rises, 12);
        chk("basic chain", a_chain, 12'hA53);

        // start in DONE starts a new session; then 10 cycles of back-pressure
        a_pulse_start();
        chk("restart done", a_done, 0);
        chk("restart ready", a_ready, 1);
        chk("restart cnt", a_cnt, 0);
        a_rises = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d ready", i), a_ready, 1);
            chk($sformatf("bp%0d cclk", i), a_cclk, 0);
            chk($sformatf("bp%0d cnt", i), a_cnt, 0);
        end
        chk("bp rises", a_rises, 0);

        // Abort during the high phase of bit 5 (abort beats a simultaneous start)
        a_send(8'h5A);
        c = 0;
        while (!(a_cnt == 4'd5 && a_cclk) && c < 40) begin
            @(posedge clk); #1; c++;
        end
        chk("abort reach bit5 high", a_cclk && a_cnt == 4'd5, 1);
        @(negedge clk); a_abort = 1'b1; a_start = 1'b1;
        @(posedge clk); #1;
        chk("abort cclk", a_cclk, 0);
        chk("abort cnt",  a_cnt,  0);
        chk("abort busy", a_busy, 0);
        chk("abort head", a_head, 0);
        chk("abort done", a_done, 0);
        @(negedge clk); a_abort = 1'b0; a_start = 1'b0;
        @(posedge clk); #1;
        chk("abort idle ready", a_ready, 0);

        // Full reload after abort
        a_rises = 0;
        a_pulse_start();
        a_send(8'h5A);
        a_send(8'hC3);
        a_wait_done("reload done");
        chk("reload rises", a_rises, 12);
        chk("reload chain", a_chain, 12'h5AC);
        chk("reload cnt", a_cnt, 12);

        // Async reset mid-SHIFT, off-edge
        a_pulse_start();
        a_send(8'hFF);
        c = 0;
        while (!a_cclk && c < 20) begin
            @(posedge clk); #1; c++;
        end
        chk("arst reach high", a_cclk, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst cclk", a_cclk, 0);
        chk("arst head", a_head, 0);
        chk("arst busy", a_busy, 0);
        chk("arst cnt",  a_cnt,  0);
        chk("arst ready", a_ready, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("arst after ready", a_ready, 0);
        chk("arst after busy", a_busy, 0);

        // Divided clock on instance B: HALF=3, byte 0xFF, 8-bit chain
        b_rises = 0;
        @(negedge clk); b_start = 1'b1;
        @(posedge clk); #1; b_start = 1'b0;
        chk("b load ready", b_ready, 1);
        @(negedge clk); b_valid = 1'b1; b_data = 8'hFF;
        @(posedge clk); #1; b_valid = 1'b0;
        pat = '0;
        sc = 0;
        c = 0;
        while (!b_done && c < 200) begin
            if (b_busy && !b_ready) begin
                if (sc < 48) pat[sc] = b_cclk;
                sc++;
            end
            @(posedge clk); #1; c++;
        end
        chk("b done", b_done, 1);
        chk("b shift cycles", sc, 48);
        chk("b clk pattern", pat, {8{6'b111000}});
        chk("b rises", b_rises, 8);
        chk("b chain", b_chain, 8'hFF);
        chk("b cnt", b_cnt, 8);
        chk("b cclk in done", b_cclk, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
